ram_n: RTL and testbench



---
 rtl/ram_n_pkg.sv | 13 +
 rtl/ram_n_if.sv | 27 ++
 rtl/ram_n_clear_seq.sv | 57 +++++
 rtl/ram_n.sv | 69 ++++++
 tb/tb_ram_n.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/ram_n_pkg.sv
// Shared definitions for the parametrised word store and its clear sequencer:
// sequencer state encodings and the default geometry reused by banked RAMs.
package ram_n_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_ADDR_W = 3;

endpackage

// File: rtl/ram_n_if.sv
// Access bus of the word store: data/address/write-enable/clear request in,
// combinational read data and clear-in-progress flag out.
interface ram_n_if
  import ram_n_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic [WIDTH-1:0]  in;
  logic [ADDR_W-1:0] address;
  logic              load;
  logic              clear;
  logic [WIDTH-1:0]  out;
  logic              busy;

  modport master (
    output in, address, load, clear,
    input  out, busy
  );

  modport slave (
    input  in, address, load, clear,
    output out, busy
  );

endinterface

// File: rtl/ram_n_clear_seq.sv
// Clear sequencer: owns the array while sweeping zeros through every word
// after reset or on a clear request accepted in IDLE.
module ram_clear_seq
  import ram_n_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  output logic              busy_o,
  output logic [ADDR_W-1:0] cnt_o,
  output logic              clr_we_o
);

  clr_state_e        state_q;
  logic [ADDR_W-1:0] cnt_q;

  // State and sweep counter; the counter wraps to 0 on the last word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= {ADDR_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clear_i) begin
            state_q <= ST_CLEAR;
            cnt_q   <= {ADDR_W{1'b0}};
          end else begin
            state_q <= ST_IDLE;
            cnt_q   <= cnt_q;
          end
        end
        ST_CLEAR: begin
          if (cnt_q == {ADDR_W{1'b1}}) begin
            state_q <= ST_IDLE;
            cnt_q   <= {ADDR_W{1'b0}};
          end else begin
            state_q <= ST_CLEAR;
            cnt_q   <= cnt_q + ADDR_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= {ADDR_W{1'b0}};
        end
      endcase
    end
  end

  assign busy_o   = (state_q == ST_CLEAR);
  assign cnt_o    = cnt_q;
  // The reset edge itself performs no array write.
  assign clr_we_o = (state_q == ST_CLEAR) && !reset;

endmodule

// File: rtl/ram_n.sv
// Parametrised 2**ADDR_W x WIDTH word store: combinational read, write on the
// rising edge when load is high, with a built-in zeroing sweep.
module ram_n
  import ram_n_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic   clk,
  input logic   reset,
  ram_n_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic              busy_s;
  logic              clr_we_s;
  logic [ADDR_W-1:0] cnt_s;
  logic              we_s;
  logic [ADDR_W-1:0] waddr_s;
  logic [WIDTH-1:0]  wdata_s;

  ram_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (bus.clear),
    .busy_o   (busy_s),
    .cnt_o    (cnt_s),
    .clr_we_o (clr_we_s)
  );

  // Write mux: the sweep wins; user loads only land in IDLE with no clear pending.
  always_comb begin
    we_s    = 1'b0;
    waddr_s = bus.address;
    wdata_s = bus.in;
    if (clr_we_s) begin
      we_s    = 1'b1;
      waddr_s = cnt_s;
      wdata_s = {WIDTH{1'b0}};
    end else if (!busy_s && !reset && !bus.clear && bus.load) begin
      we_s = 1'b1;
    end else begin
      we_s = 1'b0;
    end
  end

  // Array storage; contents are meaningful only after the first sweep.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_q[waddr_s] <= wdata_s;
    end
  end

  // Read data is masked to zero while the sweep owns the array.
  always_comb begin
    if (busy_s) begin
      bus.out = {WIDTH{1'b0}};
    end else begin
      bus.out = mem_q[bus.address];
    end
  end

  assign bus.busy = busy_s;

endmodule

// File: tb/tb_ram_n.sv
// Scoreboard bench for ram_n: default geometry plus an 8-bit x 64-word instance.
module tb_ram_n;

  logic clk;
  logic rst_a;
  logic rst_b;

  ram_n_if #(.WIDTH(16), .ADDR_W(3)) bus_a ();
  ram_n_if #(.WIDTH(8),  .ADDR_W(6)) bus_b ();

  ram_n #(.WIDTH(16), .ADDR_W(3)) dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));
  ram_n #(.WIDTH(8),  .ADDR_W(6)) dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t         sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] mdl_a [8];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push the expectation, present the address, then pop and compare.
  task automatic read_a(input string tag, input logic [2:0] addr, input logic [15:0] exp);
    sb_t e;
    sb_q.push_back('{tag: tag, exp: 32'(exp)});
    bus_a.address = addr;
    #1;
    e = sb_q.pop_front();
    check_val(e.tag, 32'(bus_a.out), e.exp);
  endtask

  task automatic read_b(input string tag, input logic [5:0] addr, input logic [7:0] exp);
    sb_t e;
    sb_q.push_back('{tag: tag, exp: 32'(exp)});
    bus_b.address = addr;
    #1;
    e = sb_q.pop_front();
    check_val(e.tag, 32'(bus_b.out), e.exp);
  endtask

  task automatic write_a(input logic [2:0] addr, input logic [15:0] data);
    @(negedge clk);
    bus_a.address = addr;
    bus_a.in      = data;
    bus_a.load    = 1'b1;
    @(negedge clk);
    bus_a.load    = 1'b0;
    mdl_a[addr]   = data;
  endtask

  // Count edges until busy drops, bounded so a stuck sequencer still ends.
  task automatic sweep_a(output int n);
    n = 0;
    while (bus_a.busy && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic sweep_b(output int n);
    n = 0;
    while (bus_b.busy && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic clear_pulse_a();
    @(negedge clk);
    bus_a.clear = 1'b1;
    @(posedge clk);
    #1;
    bus_a.clear = 1'b0;
  endtask

  initial begin
    int n;
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.in = 16'h0000; bus_a.address = 3'd0; bus_a.load = 1'b0; bus_a.clear = 1'b0;
    bus_b.in = 8'h00;    bus_b.address = 6'd0; bus_b.load = 1'b0; bus_b.clear = 1'b0;

    // Reset held for several edges keeps the block clearing at word 0.
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", 32'(bus_a.busy), 32'd1);
    read_a("rst_out", 3'd0, 16'h0000);
    rst_a = 1'b0;
    sweep_a(n);
    check_val("rst_sweep_len", n, 32'd8);
    for (int i = 0; i < 8; i++) read_a($sformatf("rst_zero%0d", i), 3'(i), 16'h0000);

    // Write/read, including no bypass before the write edge.
    @(negedge clk);
    bus_a.address = 3'd1; bus_a.in = 16'hABAB; bus_a.load = 1'b1;
    #2;
    check_val("no_bypass", 32'(bus_a.out), 32'h0000);
    @(negedge clk);
    bus_a.load = 1'b0; bus_a.in = 16'hCDCD;
    mdl_a[1] = 16'hABAB;
    read_a("wr_addr1", 3'd1, 16'hABAB);
    read_a("wr_addr2", 3'd2, 16'h0000);

    // Fill every word with a distinct value and read back.
    for (int i = 0; i < 8; i++) write_a(3'(i), 16'(16'h1111 * i) ^ 16'h0F0F);
    for (int i = 0; i < 8; i++) read_a($sformatf("fill%0d", i), 3'(i), mdl_a[i]);

    // Load held during a clear sweep is dropped; out reads zero while clearing.
    clear_pulse_a();
    read_a("clr_out_masked", 3'd6, 16'h0000);
    bus_a.load = 1'b1; bus_a.address = 3'd3; bus_a.in = 16'h1234;
    sweep_a(n);
    bus_a.load = 1'b0;
    check_val("clr_sweep_len", n, 32'd8);
    read_a("clr_load_dropped", 3'd3, 16'h0000);
    read_a("clr_addr6", 3'd6, 16'h0000);

    // Simultaneous clear and load in IDLE: clear wins.
    write_a(3'd5, 16'h1111);
    @(negedge clk);
    bus_a.clear = 1'b1; bus_a.load = 1'b1; bus_a.address = 3'd5; bus_a.in = 16'hFFFF;
    @(posedge clk);
    #1;
    bus_a.clear = 1'b0; bus_a.load = 1'b0;
    sweep_a(n);
    check_val("clrld_sweep_len", n, 32'd8);
    read_a("clrld_addr5", 3'd5, 16'h0000);

    // Reset on the 4th clear edge restarts a full sweep.
    for (int i = 0; i < 8; i++) write_a(3'(i), 16'hAAAA);
    clear_pulse_a();
    repeat (3) begin @(posedge clk); #1; end
    rst_a = 1'b1;
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    check_val("midrst_busy", 32'(bus_a.busy), 32'd1);
    sweep_a(n);
    check_val("midrst_sweep_len", n, 32'd8);
    for (int i = 0; i < 8; i++) read_a($sformatf("midrst_zero%0d", i), 3'(i), 16'h0000);

    // Wide-address instance: 64-edge sweep, top-word write.
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    sweep_b(n);
    check_val("b_sweep_len", n, 32'd64);
    @(negedge clk);
    bus_b.address = 6'd63; bus_b.in = 8'h5A; bus_b.load = 1'b1;
    @(negedge clk);
    bus_b.load = 1'b0;
    read_b("b_addr63", 6'd63, 8'h5A);
    read_b("b_addr0", 6'd0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
